// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch PC generator.
package pc_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } pc_state_e;

   // Winning redirect source, lowest to highest priority.
   typedef enum logic [1:0] {
      SEQ  = 2'd0,
      BR   = 2'd1,
      ERET = 2'd2,
      EXC  = 2'd3
   } redir_sel_e;

   localparam int          PC_WIDTH_DEF  = 32;
   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;
   localparam int          PC_INC_DEF    = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Request/response bundle between the fetch control logic and pc_gen.
// pc_misalign exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_gen_if #(
   parameter int WIDTH = 32
);
   logic             en;
   logic             br_valid;
   logic [WIDTH-1:0] br_target;
   logic             eret_req;
   logic [WIDTH-1:0] epc;
   logic             exc_req;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_inc;
   logic             redir_pend;
`ifdef PC_ALIGN_CHECK_EN
   logic             pc_misalign;

   modport master (
      output en, br_valid, br_target, eret_req, epc, exc_req,
      input  pc, pc_inc, redir_pend, pc_misalign
   );
   modport slave (
      input  en, br_valid, br_target, eret_req, epc, exc_req,
      output pc, pc_inc, redir_pend, pc_misalign
   );
`else
   modport master (
      output en, br_valid, br_target, eret_req, epc, exc_req,
      input  pc, pc_inc, redir_pend
   );
   modport slave (
      input  en, br_valid, br_target, eret_req, epc, exc_req,
      output pc, pc_inc, redir_pend
   );
`endif
endinterface

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect select: exc > eret > branch > fall-through.
// The fall-through target is supplied by the caller (pc_inc or a pending target).
module pc_redirect_arb
   import pc_pkg::*;
#(
   parameter int               WIDTH   = PC_WIDTH_DEF,
   parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(EXC_VEC_DEF)
) (
   input  logic             exc_req_i,
   input  logic             eret_req_i,
   input  logic             br_valid_i,
   input  logic [WIDTH-1:0] epc_i,
   input  logic [WIDTH-1:0] br_target_i,
   input  logic [WIDTH-1:0] fall_tgt_i,
   output redir_sel_e       sel_o,
   output logic [WIDTH-1:0] tgt_o
);

   always_comb begin
      sel_o = SEQ;
      tgt_o = fall_tgt_i;
      if (exc_req_i) begin
         sel_o = EXC;
         tgt_o = EXC_VEC;
      end else if (eret_req_i) begin
         sel_o = ERET;
         tgt_o = epc_i;
      end else if (br_valid_i) begin
         sel_o = BR;
         tgt_o = br_target_i;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with stall-tolerant redirect capture (RUN/PEND FSM).
// Optional misalignment flag built when PC_ALIGN_CHECK_EN is defined.
module pc_gen
   import pc_pkg::*;
#(
   parameter int               WIDTH     = PC_WIDTH_DEF,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
   parameter int               INC       = PC_INC_DEF
) (
   input  logic     clk,
   input  logic     reset,
   pc_gen_if.slave  bus
);

   pc_state_e        state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] fall_tgt;
   redir_sel_e       sel;
   logic [WIDTH-1:0] tgt;

   assign pc_inc   = pc_q + WIDTH'(INC);
   // With no new request, a held redirect takes the place of the sequential PC.
   assign fall_tgt = (state_q == PEND) ? pend_q : pc_inc;

   pc_redirect_arb #(
      .WIDTH   (WIDTH),
      .EXC_VEC (EXC_VEC)
   ) u_arb (
      .exc_req_i   (bus.exc_req),
      .eret_req_i  (bus.eret_req),
      .br_valid_i  (bus.br_valid),
      .epc_i       (bus.epc),
      .br_target_i (bus.br_target),
      .fall_tgt_i  (fall_tgt),
      .sel_o       (sel),
      .tgt_o       (tgt)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      if (sel == EXC) begin
         pc_d    = tgt;
         pend_d  = '0;
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (bus.en) begin
                  pc_d = tgt;
               end else if (sel != SEQ) begin
                  pend_d  = tgt;
                  state_d = PEND;
               end
            end
            PEND: begin
               if (bus.en) begin
                  pc_d    = tgt;
                  pend_d  = '0;
                  state_d = RUN;
               end else if (sel != SEQ) begin
                  pend_d = tgt;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         pc_q    <= RESET_VEC;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pc_inc     = pc_inc;
   assign bus.redir_pend = (state_q == PEND);

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   // Registered alongside pc so the flag describes the PC currently presented.
   assign misalign_d = |pc_d[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end

   assign bus.pc_misalign = misalign_q;
`endif

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32: PC width in bits.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_4180: exception handler entry address.
REQ-004 Parameter INC, default 4: sequential increment.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low; 0 resets all state immediately.
REQ-007 en  in  1  fetch enable; 0 = stall, so the PC holds.
REQ-008 br_valid  in  1  branch/jump redirect request.
REQ-009 br_target  in  WIDTH  branch/jump target.
REQ-010 eret_req  in  1  exception-return request.
REQ-011 epc  in  WIDTH  exception-return address.
REQ-012 exc_req  in  1  exception request.
REQ-013 pc  out  WIDTH  current fetch PC (registered).
REQ-014 pc_inc  out  WIDTH  pc + INC (combinational).
REQ-015 redir_pend  out  1  a redirect is captured and waiting for en.
REQ-016 pc_misalign  out  1  pc[1:0] != 0 (present only with the macro).

Function
REQ-017 Redirect priority SHALL be fixed: exc_req > eret_req > br_valid > sequential.
REQ-018 pc_inc SHALL equal (pc + INC) mod 2^WIDTH; all-ones wraps to INC-1 with no carry out.
REQ-019 State machine SHALL have two states, RUN and PEND; the state after reset is RUN.
REQ-020 RUN, en=1: pc SHALL take the highest-priority redirect target, otherwise pc_inc, on the next edge.
REQ-021 RUN, en=0, eret_req or br_valid: pc SHALL hold, the target is latched into a pending register, and the state moves to PEND.
REQ-022 PEND, en=0: pc SHALL hold.
REQ-023 PEND, en=0, new eret/branch request: the pending register SHALL be overwritten; a later request of equal or higher priority replaces the earlier one.
REQ-024 PEND, en=1: pc SHALL load a simultaneous eret/branch target if one is present, otherwise the pending target, and the state returns to RUN.
REQ-025 exc_req SHALL ignore en, load EXC_VEC on the next edge, clear any pending redirect, and go to RUN.
REQ-026 redir_pend SHALL be 1 exactly when the state is PEND.
REQ-027 Latency: a redirect applied under en=1 SHALL be visible on pc one cycle after the request cycle.

Reset
REQ-028 While reset=0: pc=RESET_VEC, state=RUN, pending register=0, redir_pend=0, pc_misalign=0.
REQ-029 Reset asserted mid-PEND SHALL discard the pending redirect; the first edge after release (en=1) SHALL load RESET_VEC+INC.

Configuration
REQ-030 Macro PC_ALIGN_CHECK_EN defined: pc_misalign SHALL be driven as registered (next_pc[1:0] != 0), and the PC value SHALL be unaltered.
REQ-031 Macro absent: the pc_misalign port SHALL not exist and no check logic is built.

Structure
REQ-032 Package pc_pkg SHALL hold the state enum (RUN, PEND), the redirect-select enum (SEQ, BR, ERET, EXC) and the default vector constants.
REQ-033 Sub-module pc_redirect_arb (combinational priority select and target mux) SHALL be instantiated once.

Verification
REQ-034 Reset: reset=0 then 1, en=1 -> pc 0x0 -> 0x4 -> 0x8 on successive edges.
REQ-035 Stalled branch: en=0, br_valid with target 0x100 for 1 cycle -> redir_pend=1 and pc holds; en=1 -> pc=0x100 and redir_pend=0.
REQ-036 Priority: exc_req, eret_req (epc=0x200) and br_valid (0x300) in the same cycle with en=0 -> pc=0x4180 next edge and redir_pend=0.
REQ-037 Wrap: pc=0xFFFF_FFFC, en=1 -> pc=0x0000_0000.
REQ-038 Reset mid-PEND: pending target 0x500, reset pulsed -> pc=0x0 and redir_pend=0; 0x500 is never fetched.
REQ-039 With PC_ALIGN_CHECK_EN: br_target 0x102, en=1 -> pc=0x102 and pc_misalign=1 in the same cycle.
